// File: rtl/emd_pkg.sv
// Shared EMD parameters: default sample width, stage latencies and the
// signed saturation limits for the residue/IMF arithmetic.
package emd_pkg;

    localparam int DW_DEF = 16;
    localparam int D1_DEF = 120;
    localparam int D2_DEF = 120;

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/delay_line.sv
// CE-qualified circular-buffer delay of DEPTH samples. dout is the sample
// written DEPTH CE-cycles ago (read-before-write at the write pointer).
module delay_line
    import emd_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = D2_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] wptr_d;

    assign dout = mem_q[wptr_q];

    always_comb begin
        wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q <= '0;
        end else if (CE) begin
            wptr_q <= wptr_d;
        end
    end

    // Storage is deliberately not reset so it can map onto RAM.
    always_ff @(posedge CLK) begin
        if (CE) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/imf_split.sv
// Splits the EMD stage residues into IMF1, IMF2 and the final residue by
// aligning Xin and R1 to R2 and subtracting with saturation.
module imf_split
    import emd_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int D1 = D1_DEF,
    parameter int D2 = D2_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    input  logic [DW-1:0] Xin,
    input  logic [DW-1:0] R1,
    input  logic [DW-1:0] R2,
    output logic [DW-1:0] IMF1,
    output logic [DW-1:0] IMF2,
    output logic [DW-1:0] RES,
    output logic          OUT_VALID
);

    localparam int            DT   = D1 + D2;
    localparam int            CW   = $clog2(DT + 1);
    localparam logic [DW-1:0] SMAX = DW'(sat_max(DW));
    localparam logic [DW-1:0] SMIN = DW'(sat_min(DW));

    // Flow: one sample is accepted on every CE=1 cycle (no back-pressure);
    // its result appears one cycle later, qualified by a single-cycle OUT_VALID.

    logic [DW-1:0] x_dly;
    logic [DW-1:0] r1_dly;
    logic [CW-1:0] warm_q;
    logic [CW-1:0] warm_d;
    logic [DW-1:0] imf1_q, imf1_d;
    logic [DW-1:0] imf2_q, imf2_d;
    logic [DW-1:0] res_q, res_d;
    logic          valid_q, valid_d;
    logic          warm;

    delay_line #(.DW(DW), .DEPTH(DT)) u_x_dly (
        .CLK  (CLK),
        .RST  (RST),
        .CE   (CE),
        .din  (Xin),
        .dout (x_dly)
    );

    delay_line #(.DW(DW), .DEPTH(D2)) u_r1_dly (
        .CLK  (CLK),
        .RST  (RST),
        .CE   (CE),
        .din  (R1),
        .dout (r1_dly)
    );

    // One extra bit of headroom; overflow shows as the top two bits differing.
    function automatic logic [DW-1:0] sub_sat(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW:0] d;
        d = {a[DW-1], a} - {b[DW-1], b};
        if (d[DW] != d[DW-1]) begin
            return d[DW] ? SMIN : SMAX;
        end
        return d[DW-1:0];
    endfunction

    assign warm = (warm_q == CW'(DT));

    always_comb begin
        warm_d  = warm_q;
        imf1_d  = imf1_q;
        imf2_d  = imf2_q;
        res_d   = res_q;
        valid_d = 1'b0;
        if (CE) begin
            if (!warm) begin
                warm_d = warm_q + CW'(1);
            end
            // Stale buffer contents are masked until DT samples have been written.
            if (warm) begin
                imf1_d  = sub_sat(x_dly, r1_dly);
                imf2_d  = sub_sat(r1_dly, R2);
                res_d   = R2;
                valid_d = 1'b1;
            end else begin
                imf1_d = '0;
                imf2_d = '0;
                res_d  = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            warm_q  <= '0;
            imf1_q  <= '0;
            imf2_q  <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            warm_q  <= warm_d;
            imf1_q  <= imf1_d;
            imf2_q  <= imf2_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign IMF1      = imf1_q;
    assign IMF2      = imf2_q;
    assign RES       = res_q;
    assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_imf_split.sv
// Self-checking bench for imf_split against a history-based reference model.
module tb_imf_split;

    localparam int DW   = 16;
    localparam int D1   = 120;
    localparam int D2   = 120;
    localparam int DT   = D1 + D2;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ce;
    logic signed [DW-1:0] xin, r1, r2;
    logic signed [DW-1:0] imf1, imf2, res;
    logic                 out_valid;

    int checks   = 0;
    int failures = 0;

    // Model state: every CE-accepted sample since the last reset.
    int                   xs[$];
    int                   r1s[$];
    int                   r2s[$];
    logic                 exp_v;
    logic signed [DW-1:0] exp1, exp2, exp3;
    int                   exp_src;
    logic                 exp_nosat;

    imf_split #(.DW(DW), .D1(D1), .D2(D2)) dut (
        .CLK       (clk),
        .RST       (rst),
        .CE        (ce),
        .Xin       (xin),
        .R1        (r1),
        .R2        (r2),
        .IMF1      (imf1),
        .IMF2      (imf2),
        .RES       (res),
        .OUT_VALID (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic signed [DW-1:0] sat(input int d);
        int t;
        t = (d > MAXV) ? MAXV : (d < MINV) ? MINV : d;
        return t[DW-1:0];
    endfunction

    // Drive one cycle, then advance the model to what the outputs must show.
    task automatic step(input logic r, input logic c, input int x, input int a, input int b);
        int k;
        int d1, d2;
        int t;
        rst = r;
        ce  = c;
        xin = x[DW-1:0];
        r1  = a[DW-1:0];
        r2  = b[DW-1:0];
        @(posedge clk);
        #1;
        if (r) begin
            xs.delete();
            r1s.delete();
            r2s.delete();
            exp_v = 1'b0;
            exp1  = '0;
            exp2  = '0;
            exp3  = '0;
        end else if (c) begin
            xs.push_back(int'(xin));
            r1s.push_back(int'(r1));
            r2s.push_back(int'(r2));
            k = xs.size() - 1;
            if (k >= DT) begin
                d1        = xs[k-DT] - r1s[k-D2];
                d2        = r1s[k-D2] - r2s[k];
                exp_v     = 1'b1;
                exp1      = sat(d1);
                exp2      = sat(d2);
                t         = r2s[k];
                exp3      = t[DW-1:0];
                exp_src   = xs[k-DT];
                exp_nosat = (d1 <= MAXV) && (d1 >= MINV) && (d2 <= MAXV) && (d2 >= MINV);
            end else begin
                exp_v = 1'b0;
                exp1  = '0;
                exp2  = '0;
                exp3  = '0;
            end
        end else begin
            exp_v = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, int'($urandom), int'($urandom), int'($urandom));
            checks++;
            if (out_valid !== 1'b0 || imf1 !== 0 || imf2 !== 0 || res !== 0) begin
                failures++;
                $display("FAIL reset: valid=%0b imf1=%0d imf2=%0d res=%0d, required all 0",
                         out_valid, imf1, imf2, res);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, int'($urandom), int'($urandom), int'($urandom));
            checks++;
            if (out_valid !== 1'b0 || imf1 !== 0 || imf2 !== 0 || res !== 0) begin
                failures++;
                $display("FAIL warmup_zero: valid=%0b imf1=%0d imf2=%0d res=%0d, required all 0",
                         out_valid, imf1, imf2, res);
            end
        end
    endtask

    task automatic test_ramp();
        step(1'b1, 1'b0, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            step(1'b0, 1'b1, k, k - D2, k - DT);
            checks++;
            if (out_valid !== exp_v || imf1 !== exp1 || imf2 !== exp2 || res !== exp3) begin
                failures++;
                $display("FAIL ramp k=%0d: got v=%0b %0d/%0d/%0d, required v=%0b %0d/%0d/%0d",
                         k, out_valid, imf1, imf2, res, exp_v, exp1, exp2, exp3);
            end
        end
        checks++;
        if (out_valid !== 1'b1 || imf1 !== 0 || imf2 !== 0 || res !== 16'sd359) begin
            failures++;
            $display("FAIL ramp_end: got v=%0b %0d/%0d/%0d, required v=1 0/0/359",
                     out_valid, imf1, imf2, res);
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < DT + 20; i++) begin
            step(1'b0, 1'b1, 30000, -30000, int'($urandom_range(0, 2000)) - 1000);
            checks++;
            if (out_valid !== exp_v || imf1 !== exp1 || imf2 !== exp2 || res !== exp3) begin
                failures++;
                $display("FAIL sat_pos i=%0d: got v=%0b %0d/%0d/%0d, required v=%0b %0d/%0d/%0d",
                         i, out_valid, imf1, imf2, res, exp_v, exp1, exp2, exp3);
            end
        end
        checks++;
        if (imf1 !== 16'sh7fff) begin
            failures++;
            $display("FAIL sat_max: imf1=%0d, required 32767", imf1);
        end
        for (int i = 0; i < DT + 20; i++) begin
            step(1'b0, 1'b1, -30000, 30000, int'($urandom_range(0, 2000)) - 1000);
            checks++;
            if (out_valid !== exp_v || imf1 !== exp1 || imf2 !== exp2 || res !== exp3) begin
                failures++;
                $display("FAIL sat_neg i=%0d: got v=%0b %0d/%0d/%0d, required v=%0b %0d/%0d/%0d",
                         i, out_valid, imf1, imf2, res, exp_v, exp1, exp2, exp3);
            end
        end
        checks++;
        if (imf1 !== 16'sh8000) begin
            failures++;
            $display("FAIL sat_min: imf1=%0d, required -32768", imf1);
        end
    endtask

    task automatic test_ce_toggle();
        int k;
        k = 0;
        step(1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 2 * (DT + 40); i++) begin
            if (i % 2 == 0) begin
                step(1'b0, 1'b1, k, k - D2, k - DT);
                k++;
            end else begin
                step(1'b0, 1'b0, int'($urandom), int'($urandom), int'($urandom));
            end
            checks++;
            if (out_valid !== exp_v || imf1 !== exp1 || imf2 !== exp2 || res !== exp3) begin
                failures++;
                $display("FAIL ce_toggle i=%0d: got v=%0b %0d/%0d/%0d, required v=%0b %0d/%0d/%0d",
                         i, out_valid, imf1, imf2, res, exp_v, exp1, exp2, exp3);
            end
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b0, 0, 0, 0);
        for (int k = 0; k < 1400; k++) begin
            step((k == 1000), 1'b1, k, k - D2, k - DT);
            checks++;
            if (out_valid !== exp_v || imf1 !== exp1 || imf2 !== exp2 || res !== exp3) begin
                failures++;
                $display("FAIL mid_reset k=%0d: got v=%0b %0d/%0d/%0d, required v=%0b %0d/%0d/%0d",
                         k, out_valid, imf1, imf2, res, exp_v, exp1, exp2, exp3);
            end
        end
    endtask

    task automatic test_random();
        int x, a, b;
        logic c;
        step(1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 5000; i++) begin
            c = ($urandom_range(0, 9) != 0);
            if (i < 2500) begin
                x = int'($urandom_range(0, 65535)) - 32768;
                a = int'($urandom_range(0, 65535)) - 32768;
                b = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                x = int'($urandom_range(0, 16000)) - 8000;
                a = int'($urandom_range(0, 16000)) - 8000;
                b = int'($urandom_range(0, 16000)) - 8000;
            end
            step(1'b0, c, x, a, b);
            checks++;
            if (out_valid !== exp_v || imf1 !== exp1 || imf2 !== exp2 || res !== exp3) begin
                failures++;
                $display("FAIL random i=%0d: got v=%0b %0d/%0d/%0d, required v=%0b %0d/%0d/%0d",
                         i, out_valid, imf1, imf2, res, exp_v, exp1, exp2, exp3);
            end
            if (c && exp_v && exp_nosat) begin
                checks++;
                if (int'(imf1) + int'(imf2) + int'(res) !== exp_src) begin
                    failures++;
                    $display("FAIL reconstruct i=%0d: sum=%0d, required %0d",
                             i, int'(imf1) + int'(imf2) + int'(res), exp_src);
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        ce    = 1'b0;
        xin   = '0;
        r1    = '0;
        r2    = '0;
        exp_v = 1'b0;
        exp1  = '0;
        exp2  = '0;
        exp3  = '0;
        exp_src   = 0;
        exp_nosat = 1'b0;
        test_reset();
        test_ramp();
        test_saturation();
        test_ce_toggle();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imf_split.md
IMF_SPLIT -- requirements
Module: imf_split

Interface
REQ-001 Parameter DW, default 16: sample width, signed two's complement.
REQ-002 Parameter D1, default 120: EMD stage-1 latency in samples (R1 at sample k aligns with Xin at sample k-D1).
REQ-003 Parameter D2, default 120: EMD stage-2 latency in samples (R2 at sample k aligns with R1 at sample k-D2).
REQ-004 CLK  in  1  single clock, all logic on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 CE  in  1  sample enable; one input sample per cycle with CE=1.
REQ-007 Xin  in  DW  signed raw input sample, same value fed to the EMD block.
REQ-008 R1  in  DW  signed stage-1 residue from the EMD block.
REQ-009 R2  in  DW  signed stage-2 residue from the EMD block.
REQ-010 IMF1  out  DW  signed first intrinsic mode function, registered.
REQ-011 IMF2  out  DW  signed second intrinsic mode function, registered.
REQ-012 RES  out  DW  signed final residue, registered.
REQ-013 OUT_VALID  out  1  high for exactly one cycle per valid output sample.

Function
REQ-014 On a cycle with CE=1 at input index k, the block SHALL compute IMF1=sat(Xin[k-D1-D2]-R1[k-D2]), IMF2=sat(R1[k-D2]-R2[k]), RES=R2[k].
REQ-015 Results SHALL appear on the outputs on the cycle after the CE=1 cycle (latency 1 CLK), with OUT_VALID=1 on that cycle.
REQ-016 Xin SHALL be delayed by exactly D1+D2 CE-qualified samples; R1 by exactly D2 CE-qualified samples.
REQ-017 Delay lines SHALL be circular buffers: read-before-write at the write pointer, pointer advances only on CE=1, wraps from depth-1 to 0.
REQ-018 CE=0 SHALL hold pointers, buffer contents, warm-up counter and output registers; OUT_VALID=0 on the following cycle.
REQ-019 Subtraction SHALL be done at DW+1 bits and saturate to [-2^(DW-1), 2^(DW-1)-1] (-32768..32767 at DW=16).
REQ-020 A warm-up counter SHALL count CE=1 samples and saturate at D1+D2; OUT_VALID SHALL assert only for samples with count already equal to D1+D2 (first valid is input index D1+D2 = 240).
REQ-021 While not warmed up, IMF1, IMF2 and RES SHALL be driven 0 and OUT_VALID held 0, regardless of stale buffer contents.
REQ-022 Warm-up counter SHALL never wrap; continuous operation beyond 65535 samples SHALL keep OUT_VALID asserted on every CE cycle.

Reset
REQ-023 RST=1 SHALL clear both write pointers, the warm-up counter, IMF1, IMF2, RES and OUT_VALID to 0 on the next rising edge; RST has priority over CE.
REQ-024 Buffer storage SHALL not be reset; correctness relies on REQ-021 gating.
REQ-025 RST mid-stream SHALL restart warm-up: the first valid output after reset SHALL follow the (D1+D2+1)th CE sample after RST deasserts.

Structure
REQ-026 DW, D1, D2 defaults and the saturation limits SHALL live in a shared package emd_pkg used by EMD and imf_split.
REQ-027 One sub-module delay_line (parameters DW, DEPTH; ports CLK, RST, CE, din, dout) SHALL be instantiated twice: DEPTH=D1+D2 for Xin and DEPTH=D2 for R1.
REQ-028 Buffers SHALL map to block/distributed RAM (no reset on storage, single write port, single read port).

Verification
REQ-029 Ramp Xin=k, R1=k-120, R2=k-240, CE=1 every cycle -> OUT_VALID first high after sample 240; IMF1=0, IMF2=0, RES=k-240 thereafter.
REQ-030 Xin=+30000 constant, R1=-30000 constant -> after warm-up IMF1=32767 (saturated); Xin=-30000, R1=+30000 -> IMF1=-32768.
REQ-031 CE toggled 1,0,1,0 with ramp stimulus -> outputs identical to REQ-029 per valid sample, OUT_VALID high only after CE=1 cycles, first valid after 240 CE samples (~480 cycles).
REQ-032 RST pulsed for 1 cycle at sample 1000 of REQ-029 -> OUT_VALID=0 and outputs 0 for next 240 CE samples, then ramp results resume with correct alignment.
REQ-033 Random Xin, R1, R2 for 5000 samples against a reference model -> every IMF1, IMF2, RES bit-exact, and Xin[n] == IMF1+IMF2+RES (when no saturation) at each valid output.
